antitheft_time_param_timer: RTL and testbench
=============================================

// Module: antitheft_time_param_timer
// PURPOSE
//  Timer/time-parameter side of the anti-theft FSM's startTimer/interval/expired interface.
//  Holds four programmable delay values and, on startTimer, counts the selected value down in
//  1 s steps derived from clock1Hz, then raises expired. Sits beside the anti-theft FSM: the FSM
//  drives startTimer/interval, this block returns expired.
// PARAMETERS
//  T_ARM_DELAY     6   default seconds, interval=2'b00 (arming delay)
//  T_DRIVER_DELAY  8   default seconds, interval=2'b01 (driver-door delay)
//  T_PASS_DELAY    15  default seconds, interval=2'b10 (passenger-door delay)
//  T_ALARM_ON      10  default seconds, interval=2'b11 (siren-on time)
//  VAL_W           4   width of stored/counted values
// PORTS
//  clock        in   1      system clock; all state on rising edge
//  systemReset  in   1      asynchronous, active-high reset
//  clock1Hz     in   1      1 Hz square wave, not synchronous to clock
//  startTimer   in   1      load selected interval, begin countdown
//  interval     in   2      selects which stored value startTimer loads
//  reprogram    in   1      write paramValue into register paramSelect
//  paramSelect  in   2      register index for reprogram (same encoding as interval)
//  paramValue   in   VAL_W  new value in seconds
//  expired      out  1      countdown finished; held until next load
//  busy         out  1      high while counting
//  timeLeft     out  VAL_W  remaining seconds (for display)
// BEHAVIOUR
//  Reset (async, immediate): regs <= defaults; state IDLE; expired=0, busy=0, timeLeft=0;
//   synchroniser and edge-detect flops cleared. Reset mid-count aborts with no expired pulse.
//  Tick: clock1Hz -> 2-flop synchroniser -> rising-edge detect = 1-cycle tick pulse, occurring
//   2-3 clock cycles after the clock1Hz rising edge. One tick per clock1Hz period.
//  FSM states IDLE, COUNT, DONE:
//   any state, startTimer=1 at edge: timeLeft <= reg[interval]; expired <= 0;
//    value != 0 -> COUNT (busy=1); value == 0 -> DONE, expired=1 next cycle.
//   COUNT, tick: timeLeft==1 -> timeLeft<=0, DONE, expired<=1, busy<=0; else timeLeft-=1.
//   COUNT, no tick: hold. DONE: expired stays 1 until next startTimer or reset.
//   IDLE: expired=0, busy=0; ticks ignored.
//  Latency: expired rises on the clock edge that consumes the Nth tick after load. First tick
//   phase is arbitrary, so real time = (N-1, N] s; this is accepted.
//  Priority: startTimer beats tick in the same cycle (load wins, tick discarded).
//   Restart while COUNT reloads from the new interval, no expired pulse.
//  Reprogram: reprogram=1 at edge writes reg[paramSelect] <= paramValue (0 stored as-is).
//   Does not change a countdown already running. If startTimer and reprogram happen in the same
//   cycle with paramSelect==interval, the load uses the OLD value; the new value applies from
//   the next load onward.
//  Widths: decrement never wraps. timeLeft cannot go below 0.
//  startTimer held high reloads every cycle, so the countdown stays frozen at full value.
// TESTING
//  1 Reset: systemReset pulse -> expired=0, busy=0, timeLeft=0; load intervals 00..11 give
//    6/8/15/10 respectively.
//  2 interval=01, startTimer 1 cycle -> busy=1, timeLeft=8; after 8th tick expired=1, busy=0,
//    timeLeft=0; expired stays 1 for 3 more ticks.
//  3 reprogram paramSelect=00 paramValue=3, then start interval=00 -> expired after 3rd tick.
//    Same-cycle start+reprogram(00,5) loads old 3.
//  4 interval=10 start, after 4 ticks restart with interval=00 -> timeLeft=6, no expired pulse
//    between; expires 6 ticks later.
//  5 Reprogram value 0 then start -> DONE, expired=1 one cycle after load, busy never high.
//  6 systemReset mid-count (timeLeft=5) -> immediate expired=0, busy=0, registers back to
//    defaults; start tick + startTimer in same cycle -> tick ignored.

Source files
------------

// File: rtl/antitheft_time_param_timer.sv
// antitheft_time_param_timer
// Timer and time-parameter store for the anti-theft FSM. Holds four
// programmable delays. On startTimer it loads the delay picked by interval and
// counts it down once per second, using ticks derived from clock1Hz. When the
// count reaches zero it raises expired and holds it until the next load.
//
// Ports:
//   clock        in   1      system clock, rising edge
//   systemReset  in   1      asynchronous, active-high reset
//   clock1Hz     in   1      1 Hz square wave, asynchronous to clock
//   startTimer   in   1      load the selected delay and begin counting
//   interval     in   2      which stored delay startTimer loads
//   reprogram    in   1      write paramValue into register paramSelect
//   paramSelect  in   2      register index for reprogram
//   paramValue   in   VAL_W  new delay in seconds
//   expired      out  1      countdown finished, held until the next load
//   busy         out  1      high while counting
//   timeLeft     out  VAL_W  remaining seconds
module antitheft_time_param_timer #(
   parameter int T_ARM_DELAY    = 6,
   parameter int T_DRIVER_DELAY = 8,
   parameter int T_PASS_DELAY   = 15,
   parameter int T_ALARM_ON     = 10,
   parameter int VAL_W          = 4
) (
   input  logic             clock,
   input  logic             systemReset,
   input  logic             clock1Hz,
   input  logic             startTimer,
   input  logic [1:0]       interval,
   input  logic             reprogram,
   input  logic [1:0]       paramSelect,
   input  logic [VAL_W-1:0] paramValue,
   output logic             expired,
   output logic             busy,
   output logic [VAL_W-1:0] timeLeft
);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} stateT;

   stateT            state;
   stateT            stateNext;
   logic [VAL_W-1:0] timeLeftNext;
   logic [VAL_W-1:0] paramRegs [4];
   logic [VAL_W-1:0] loadValue;
   logic             syncStage1;
   logic             syncStage2;
   logic             syncPrev;
   logic             tick;

   // The delay registers start at their defaults after reset. A reprogram
   // write lands on the same edge that a simultaneous startTimer samples, so
   // that load still sees the old value. A running countdown never looks back
   // at these registers.
   always_ff @(posedge clock or posedge systemReset) begin
      if (systemReset) begin
         paramRegs[0] <= VAL_W'(T_ARM_DELAY);
         paramRegs[1] <= VAL_W'(T_DRIVER_DELAY);
         paramRegs[2] <= VAL_W'(T_PASS_DELAY);
         paramRegs[3] <= VAL_W'(T_ALARM_ON);
      end else if (reprogram) begin
         paramRegs[paramSelect] <= paramValue;
      end
   end

   // clock1Hz is asynchronous to clock, so it passes through two flops first.
   // A third flop holds the previous synchronised level. A rising edge of the
   // synchronised signal becomes a one-cycle tick, which is consumed 2-3
   // clocks after the real edge.
   always_ff @(posedge clock or posedge systemReset) begin
      if (systemReset) begin
         syncStage1 <= 1'b0;
         syncStage2 <= 1'b0;
         syncPrev   <= 1'b0;
      end else begin
         syncStage1 <= clock1Hz;
         syncStage2 <= syncStage1;
         syncPrev   <= syncStage2;
      end
   end

   assign tick      = syncStage2 & ~syncPrev;
   assign loadValue = paramRegs[interval];

   // State and countdown registers. Reset aborts any count in progress, and
   // expired does not pulse.
   always_ff @(posedge clock or posedge systemReset) begin
      if (systemReset) begin
         state    <= IDLE;
         timeLeft <= '0;
      end else begin
         state    <= stateNext;
         timeLeft <= timeLeftNext;
      end
   end

   // Next-state logic. startTimer wins over everything, including a tick in
   // the same cycle, and reloads from any state. A zero delay goes straight to
   // DONE. While counting, the last tick moves to DONE, and the <=1 test keeps
   // the decrement from ever wrapping below zero.
   always_comb begin
      stateNext    = state;
      timeLeftNext = timeLeft;
      if (startTimer) begin
         timeLeftNext = loadValue;
         stateNext    = (loadValue != '0) ? COUNT : DONE;
      end else begin
         case (state)
            COUNT: begin
               if (tick) begin
                  if (timeLeft <= VAL_W'(1)) begin
                     timeLeftNext = '0;
                     stateNext    = DONE;
                  end else begin
                     timeLeftNext = timeLeft - VAL_W'(1);
                  end
               end
            end
            DONE:    stateNext = DONE;
            default: stateNext = IDLE;
         endcase
      end
   end

   // Both status flags come directly from the registered state, so they
   // change cleanly on clock edges and clear as soon as reset is asserted.
   assign expired = (state == DONE);
   assign busy    = (state == COUNT);

endmodule

// File: tb/tb_antitheft_time_param_timer.sv
// tb_antitheft_time_param_timer
// Directed bench for antitheft_time_param_timer. The stimulus pushes the
// expected outputs into a scoreboard queue, and a separate monitor pops each
// entry and compares it against the live DUT outputs.
module tb_antitheft_time_param_timer;

   logic       clock = 1'b0;
   logic       systemReset = 1'b1;
   logic       clock1Hz = 1'b0;
   logic       startTimer = 1'b0;
   logic [1:0] interval = 2'b00;
   logic       reprogram = 1'b0;
   logic [1:0] paramSelect = 2'b00;
   logic [3:0] paramValue = 4'd0;
   logic       expired;
   logic       busy;
   logic [3:0] timeLeft;

   typedef struct {
      string      name;
      logic       expExpired;
      logic       expBusy;
      logic [3:0] expTimeLeft;
   } expT;

   expT        sbQueue [$];
   int         assertionsEvaluated = 0;
   int         failures = 0;
   logic [3:0] defaultVals [4] = '{4'd6, 4'd8, 4'd15, 4'd10};

   antitheft_time_param_timer dut (
      .clock       (clock),
      .systemReset (systemReset),
      .clock1Hz    (clock1Hz),
      .startTimer  (startTimer),
      .interval    (interval),
      .reprogram   (reprogram),
      .paramSelect (paramSelect),
      .paramValue  (paramValue),
      .expired     (expired),
      .busy        (busy),
      .timeLeft    (timeLeft)
   );

   // 10 ns system clock
   always #5 clock = ~clock;

   // Monitor: compares each queued expectation against the DUT outputs in the
   // same timestep the stimulus posted it, which is always away from a rising edge
   initial begin : monitor
      expT e;
      forever begin
         wait (sbQueue.size() > 0);
         e = sbQueue.pop_front();
         assertionsEvaluated++;
         if (expired !== e.expExpired || busy !== e.expBusy || timeLeft !== e.expTimeLeft) begin
            failures++;
            $display("[TB] FAIL %s: got expired=%0b busy=%0b timeLeft=%0d, expected expired=%0b busy=%0b timeLeft=%0d",
                     e.name, expired, busy, timeLeft, e.expExpired, e.expBusy, e.expTimeLeft);
         end
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "[TB] timeout");
   end

   // Queue an expectation for the monitor to check against the current outputs
   task automatic checkOutput(input string name, input logic e, input logic b, input logic [3:0] t);
      expT x;
      x.name        = name;
      x.expExpired  = e;
      x.expBusy     = b;
      x.expTimeLeft = t;
      sbQueue.push_back(x);
   endtask

   // Drive one cycle of start/reprogram from a falling edge; returns on the
   // falling edge right after the rising edge that sampled it
   task automatic applyStimulus(input logic st, input logic [1:0] iv, input logic rp,
                                input logic [1:0] ps, input logic [3:0] pv);
      startTimer  = st;
      interval    = iv;
      reprogram   = rp;
      paramSelect = ps;
      paramValue  = pv;
      @(negedge clock);
      startTimer = 1'b0;
      reprogram  = 1'b0;
   endtask

   // One full clock1Hz period; the resulting tick is consumed 3 edges after the rise
   task automatic oneTick();
      clock1Hz = 1'b1;
      repeat (4) @(negedge clock);
      clock1Hz = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   // Reset pulse with a check taken while reset is still asserted
   task automatic doReset(input string name);
      systemReset = 1'b1;
      #1;
      checkOutput(name, 1'b0, 1'b0, 4'd0);
      @(negedge clock);
      systemReset = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      @(negedge clock);

      // Reset state and the default delay for each interval
      doReset("resetState");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'(i), 1'b0, 2'b00, 4'd0);
         checkOutput($sformatf("defaultLoad%0d", i), 1'b0, 1'b1, defaultVals[i]);
      end

      // Driver-door delay: 8 ticks, then expired held for 3 more ticks
      applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
      checkOutput("driverLoad", 1'b0, 1'b1, 4'd8);
      for (int i = 1; i <= 8; i++) begin
         oneTick();
         if (i < 8) checkOutput($sformatf("driverTick%0d", i), 1'b0, 1'b1, 4'(8 - i));
         else       checkOutput("driverExpired", 1'b1, 1'b0, 4'd0);
      end
      for (int i = 1; i <= 3; i++) begin
         oneTick();
         checkOutput($sformatf("driverHold%0d", i), 1'b1, 1'b0, 4'd0);
      end

      // Reprogram the arming delay to 3, then check same-cycle old-value load
      applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 4'd3);
      applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
      checkOutput("reprogLoad3", 1'b0, 1'b1, 4'd3);
      for (int i = 1; i <= 3; i++) begin
         oneTick();
         if (i < 3) checkOutput($sformatf("reprogTick%0d", i), 1'b0, 1'b1, 4'(3 - i));
         else       checkOutput("reprogExpired", 1'b1, 1'b0, 4'd0);
      end
      applyStimulus(1'b1, 2'b00, 1'b1, 2'b00, 4'd5);
      checkOutput("sameCycleOldValue", 1'b0, 1'b1, 4'd3);
      applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
      checkOutput("newValueNextLoad", 1'b0, 1'b1, 4'd5);

      // Restart mid-count with a new interval, with no expired pulse in between
      doReset("resetBeforeRestart");
      applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
      checkOutput("passLoad", 1'b0, 1'b1, 4'd15);
      for (int i = 1; i <= 4; i++) begin
         oneTick();
         checkOutput($sformatf("passTick%0d", i), 1'b0, 1'b1, 4'(15 - i));
      end
      applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
      checkOutput("restartLoad", 1'b0, 1'b1, 4'd6);
      for (int i = 1; i <= 6; i++) begin
         oneTick();
         if (i < 6) checkOutput($sformatf("restartTick%0d", i), 1'b0, 1'b1, 4'(6 - i));
         else       checkOutput("restartExpired", 1'b1, 1'b0, 4'd0);
      end

      // A zero delay goes straight to expired and never shows busy
      applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 4'd0);
      applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
      checkOutput("zeroLoadExpired", 1'b1, 1'b0, 4'd0);
      @(negedge clock);
      checkOutput("zeroLoadHold", 1'b1, 1'b0, 4'd0);

      // Reset mid-count, then check the defaults come back
      applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
      for (int i = 1; i <= 10; i++) oneTick();
      checkOutput("midCountAt5", 1'b0, 1'b1, 4'd5);
      doReset("midCountReset");
      applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
      checkOutput("defaultsRestored", 1'b0, 1'b1, 4'd8);

      // Tick and startTimer on the same edge: the load wins and the tick is discarded
      clock1Hz = 1'b1;
      repeat (2) @(negedge clock);
      applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
      checkOutput("tickDiscarded", 1'b0, 1'b1, 4'd15);
      repeat (2) @(negedge clock);
      clock1Hz = 1'b0;
      repeat (4) @(negedge clock);
      checkOutput("tickStillDiscarded", 1'b0, 1'b1, 4'd15);
      oneTick();
      checkOutput("tickAfterLoad", 1'b0, 1'b1, 4'd14);

      @(negedge clock);
      #1;
      if (sbQueue.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sbQueue.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertionsEvaluated, failures);
      $finish;
   end

endmodule
